// File: rtl/chimera_pmu_pkg.sv
// Shared types and constants for the cluster power-management controller.
package chimera_pmu_pkg;

    localparam int unsigned PmuSettleWidth  = 8;
    localparam int unsigned PmuTimeoutWidth = 16;

    localparam int unsigned PmuTargetOffs = 32'h00;
    localparam int unsigned PmuStatusOffs = 32'h04;
    localparam int unsigned PmuErrOffs    = 32'h08;
    localparam int unsigned PmuDelayOffs  = 32'h0C;

    typedef enum logic [2:0] {
        PMU_OFF,
        PMU_CLK_ON,
        PMU_RST_REL,
        PMU_DEISO,
        PMU_ON,
        PMU_ISO,
        PMU_RST_ASRT,
        PMU_CLK_OFF
    } pmu_state_e;

    typedef struct packed {
        logic rst_n;
        logic clkgate_en;
        logic iso_en;
        logic on;
        logic busy;
    } pmu_outs_t;

    // Moore output decode for a sequencer state.
    function automatic pmu_outs_t pmu_outs(pmu_state_e s);
        pmu_outs_t o;
        o = '{rst_n: 1'b0, clkgate_en: 1'b1, iso_en: 1'b1, on: 1'b0, busy: 1'b1};
        case (s)
            PMU_OFF:      o.busy = 1'b0;
            PMU_CLK_ON:   o.clkgate_en = 1'b0;
            PMU_RST_REL:  begin o.rst_n = 1'b1; o.clkgate_en = 1'b0; end
            PMU_DEISO:    begin o.rst_n = 1'b1; o.clkgate_en = 1'b0; o.iso_en = 1'b0; end
            PMU_ON:       begin
                o.rst_n = 1'b1; o.clkgate_en = 1'b0; o.iso_en = 1'b0;
                o.on = 1'b1; o.busy = 1'b0;
            end
            PMU_ISO:      begin o.rst_n = 1'b1; o.clkgate_en = 1'b0; end
            PMU_RST_ASRT: o.clkgate_en = 1'b0;
            default:      ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/chimera_pmu_seq.sv
// One cluster's power sequencer: timed settle states, ack waits with timeout.
module chimera_pmu_seq
    import chimera_pmu_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       target,
    input  logic [PmuSettleWidth-1:0]  settle,
    input  logic [PmuTimeoutWidth-1:0] timeout,
    input  logic                       iso_ack,
    output logic                       clu_rst_n,
    output logic                       clkgate_en,
    output logic                       iso_en,
    output logic                       on,
    output logic                       busy,
    output logic                       timeout_c
);

    localparam int unsigned CntWidth = PmuTimeoutWidth;

    pmu_state_e          state;
    pmu_outs_t           outs;
    logic [CntWidth-1:0] cnt;
    logic [CntWidth-1:0] lim;
    logic                settled;
    logic                waiting;
    logic                ack_ok;

    assign settled   = (cnt == lim);
    assign waiting   = (state == PMU_DEISO) || (state == PMU_ISO);
    assign ack_ok    = (state == PMU_DEISO) ? !iso_ack : iso_ack;
    // lim holds the captured timeout in wait states; zero disables the timeout
    assign timeout_c = waiting && !ack_ok && (lim != '0) && (cnt == lim - CntWidth'(1));

    assign clu_rst_n  = outs.rst_n;
    assign clkgate_en = outs.clkgate_en;
    assign iso_en     = outs.iso_en;
    assign on         = outs.on;
    assign busy       = outs.busy;

    // Settle/timeout limits are captured on entry so mid-state writes only affect later states.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= PMU_OFF;
            outs  <= pmu_outs(PMU_OFF);
            cnt   <= '0;
            lim   <= '0;
        end else begin
            cnt <= cnt + CntWidth'(1);
            case (state)
                PMU_OFF: if (target) begin
                    state <= PMU_CLK_ON;   outs <= pmu_outs(PMU_CLK_ON);
                    cnt   <= '0;           lim  <= CntWidth'(settle);
                end
                PMU_CLK_ON: if (settled) begin
                    state <= PMU_RST_REL;  outs <= pmu_outs(PMU_RST_REL);
                    cnt   <= '0;           lim  <= CntWidth'(settle);
                end
                PMU_RST_REL: if (settled) begin
                    state <= PMU_DEISO;    outs <= pmu_outs(PMU_DEISO);
                    cnt   <= '0;           lim  <= timeout;
                end
                PMU_DEISO: if (ack_ok || timeout_c) begin
                    state <= PMU_ON;       outs <= pmu_outs(PMU_ON);
                    cnt   <= '0;
                end
                PMU_ON: if (!target) begin
                    state <= PMU_ISO;      outs <= pmu_outs(PMU_ISO);
                    cnt   <= '0;           lim  <= timeout;
                end
                PMU_ISO: if (ack_ok || timeout_c) begin
                    state <= PMU_RST_ASRT; outs <= pmu_outs(PMU_RST_ASRT);
                    cnt   <= '0;           lim  <= CntWidth'(settle);
                end
                PMU_RST_ASRT: if (settled) begin
                    state <= PMU_CLK_OFF;  outs <= pmu_outs(PMU_CLK_OFF);
                    cnt   <= '0;           lim  <= CntWidth'(settle);
                end
                PMU_CLK_OFF: if (settled) begin
                    state <= PMU_OFF;      outs <= pmu_outs(PMU_OFF);
                    cnt   <= '0;
                end
                default: begin
                    state <= PMU_OFF;      outs <= pmu_outs(PMU_OFF);
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/chimera_pmu_ctrl.sv
// Cluster power-management controller: APB register file plus one sequencer per cluster.
module chimera_pmu_ctrl
    import chimera_pmu_pkg::*;
#(
    parameter int unsigned                NumClusters    = 5,
    parameter int unsigned                AddrWidth      = 12,
    parameter logic [PmuSettleWidth-1:0]  DefaultSettle  = 8'd16,
    parameter logic [PmuTimeoutWidth-1:0] DefaultTimeout = 16'd1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   apb_psel_i,
    input  logic                   apb_penable_i,
    input  logic                   apb_pwrite_i,
    input  logic [AddrWidth-1:0]   apb_paddr_i,
    input  logic [31:0]            apb_pwdata_i,
    output logic [31:0]            apb_prdata_o,
    output logic                   apb_pready_o,
    output logic                   apb_pslverr_o,
    output logic [NumClusters-1:0] clu_rst_no,
    output logic [NumClusters-1:0] clu_clkgate_en_o,
    output logic [NumClusters-1:0] clu_iso_en_o,
    input  logic [NumClusters-1:0] clu_iso_ack_i,
    output logic                   irq_o
);

    logic                       access;
    logic                       wr;
    logic [AddrWidth-1:0]       word_addr;
    logic                       sel_target, sel_status, sel_err, sel_delay, mapped;
    logic [NumClusters-1:0]     target_q, err_q, err_d, on, busy, tmo;
    logic [PmuSettleWidth-1:0]  settle_q;
    logic [PmuTimeoutWidth-1:0] timeout_q;
    logic                       irq_q;
    logic                       unused_bits;

    assign access     = apb_psel_i & apb_penable_i;
    assign word_addr  = apb_paddr_i & ~AddrWidth'(3);
    assign sel_target = (word_addr == AddrWidth'(PmuTargetOffs));
    assign sel_status = (word_addr == AddrWidth'(PmuStatusOffs));
    assign sel_err    = (word_addr == AddrWidth'(PmuErrOffs));
    assign sel_delay  = (word_addr == AddrWidth'(PmuDelayOffs));
    assign mapped     = sel_target | sel_status | sel_err | sel_delay;
    assign wr         = access & apb_pwrite_i;

    assign apb_pready_o  = 1'b1;
    assign apb_pslverr_o = access & ~mapped;
    assign irq_o         = irq_q;
    assign unused_bits   = ^{apb_paddr_i[1:0], apb_pwdata_i};

    // W1C clear applied first so a same-cycle timeout keeps its bit set.
    always_comb begin
        err_d = err_q;
        if (wr && sel_err) begin
            err_d = err_d & ~apb_pwdata_i[NumClusters-1:0];
        end
        err_d = err_d | tmo;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            target_q  <= '0;
            err_q     <= '0;
            settle_q  <= DefaultSettle;
            timeout_q <= DefaultTimeout;
            irq_q     <= 1'b0;
        end else begin
            if (wr && sel_target) begin
                target_q <= apb_pwdata_i[NumClusters-1:0];
            end
            if (wr && sel_delay) begin
                settle_q  <= apb_pwdata_i[PmuSettleWidth-1:0];
                timeout_q <= apb_pwdata_i[16 +: PmuTimeoutWidth];
            end
            err_q <= err_d;
            irq_q <= |err_d;
        end
    end

    always_comb begin
        apb_prdata_o = '0;
        if (access && !apb_pwrite_i) begin
            if (sel_target) apb_prdata_o = 32'(target_q);
            if (sel_status) apb_prdata_o = (32'(busy) << 16) | 32'(on);
            if (sel_err)    apb_prdata_o = 32'(err_q);
            if (sel_delay)  apb_prdata_o = {timeout_q, 8'h00, settle_q};
        end
    end

    for (genvar i = 0; i < int'(NumClusters); i++) begin : g_seq
        chimera_pmu_seq u_seq (
            .clk        (clk_i),
            .rst_n      (rst_ni),
            .target     (target_q[i]),
            .settle     (settle_q),
            .timeout    (timeout_q),
            .iso_ack    (clu_iso_ack_i[i]),
            .clu_rst_n  (clu_rst_no[i]),
            .clkgate_en (clu_clkgate_en_o[i]),
            .iso_en     (clu_iso_en_o[i]),
            .on         (on[i]),
            .busy       (busy[i]),
            .timeout_c  (tmo[i])
        );
    end

endmodule

// File: doc/chimera_pmu_ctrl.md
Name: chimera_pmu_ctrl

Overview:
- Power-management controller that drives the per-cluster reset, clock-gate and isolation requests into the cluster domain.
- Consumes the isolation acknowledges coming back from the cluster domain.
- Software programs it over an APB completer port; it sits in the SoC clock domain next to the external APB config path.
- One sequencer per cluster runs fixed power-up and power-down orderings, with settle delays and an acknowledge timeout.

Parameters:
- NumClusters, 5, number of controlled clusters (1..16).
- AddrWidth, 12, APB address width.
- DefaultSettle, 8'd16, reset value of the settle-cycle field.
- DefaultTimeout, 16'd1024, reset value of the isolation-ack timeout field.

Ports:
- clk_i  in  1  SoC clock.
- rst_ni  in  1  synchronous active-low reset.
- apb_psel_i  in  1  APB select.
- apb_penable_i  in  1  APB enable.
- apb_pwrite_i  in  1  APB write.
- apb_paddr_i  in  AddrWidth  byte address.
- apb_pwdata_i  in  32  write data.
- apb_prdata_o  out  32  read data.
- apb_pready_o  out  1  ready.
- apb_pslverr_o  out  1  error.
- clu_rst_no  out  NumClusters  cluster reset, active low.
- clu_clkgate_en_o  out  NumClusters  1 = cluster clock gated off.
- clu_iso_en_o  out  NumClusters  1 = isolation requested.
- clu_iso_ack_i  in  NumClusters  isolation acknowledge from the cluster domain.
- irq_o  out  1  level interrupt, high while any ERR bit is set.

Behaviour:
- Reset and clocking: one clock, clk_i. Reset is synchronous and active-low on rst_ni. All flops load on the clock edge at which rst_ni=0.
- Reset values:
  - clu_rst_no='0, clu_clkgate_en_o='1, clu_iso_en_o='1 (all clusters OFF).
  - prdata=0, pslverr=0, pready=1, irq_o=0.
  - TARGET=0, ERR=0, SETTLE=DefaultSettle, TIMEOUT=DefaultTimeout.
- APB:
  - Zero wait states. pready_o is constantly 1.
  - A transfer completes in the access phase (psel&penable).
  - Writes commit on that edge. prdata is driven combinationally from the registers during the access phase.
  - An unmapped address sets pslverr=1 in the access phase; writes to it are discarded and reads return 0.
  - Only paddr[AddrWidth-1:2] is decoded.
- Registers:
  - 0x00 TARGET, RW, [NumClusters-1:0]: 1=on requested.
  - 0x04 STATUS, RO: [i]=cluster i in ON; [16+i]=cluster i sequencing (not ON or OFF).
  - 0x08 ERR, W1C, [i]: isolation timeout on cluster i. A hardware set in the same cycle as a W1C of that bit wins.
  - 0x0C DELAY, RW: [7:0] SETTLE, [31:16] TIMEOUT.
- Sequencer states per cluster, with outputs (rst_n, clkgate_en, iso_en):
  - OFF (0,1,1).
  - CLK_ON (0,0,1).
  - RST_REL (1,0,1).
  - DEISO (1,0,0).
  - ON (1,0,0).
  - ISO (1,0,1).
  - RST_ASRT (0,0,1).
  - CLK_OFF (0,1,1).
- Outputs are Moore and registered: they change on the edge that enters the state.
- Power-up path:
  - OFF to CLK_ON when TARGET[i]=1.
  - CLK_ON to RST_REL after SETTLE+1 cycles in CLK_ON.
  - RST_REL to DEISO after SETTLE+1 cycles.
  - DEISO to ON on the first cycle iso_ack=0.
- Power-down path:
  - ON to ISO when TARGET[i]=0.
  - ISO to RST_ASRT on the first cycle iso_ack=1.
  - RST_ASRT to CLK_OFF after SETTLE+1 cycles.
  - CLK_OFF to OFF after SETTLE+1 cycles.
- SETTLE=0 gives exactly 1 cycle per timed state.
- Timeout:
  - A 16-bit cycle counter runs in DEISO and ISO.
  - If it reaches TIMEOUT without the expected ack, set ERR[i] and advance anyway (forced).
  - TIMEOUT=0 means the timeout is disabled; the sequencer waits indefinitely.
- TARGET sampling: TARGET is sampled only in OFF and ON. A change mid-sequence is honoured after the current sequence ends, never aborted.
- Settings changes: SETTLE and TIMEOUT are captured into the sequencer when it enters each timed or wait state. Writes mid-state affect only later states.
- Ack glitches: clu_iso_ack_i is ignored outside DEISO and ISO.
- Independence: clusters sequence independently and concurrently.
- Reset mid-sequence: any state returns to OFF with reset outputs. There are no intermediate glitches, because outputs are registered.

Decomposition:
- chimera_pmu_pkg holds:
  - the state enum pmu_state_e;
  - register offsets PmuTargetOffs, PmuStatusOffs, PmuErrOffs, PmuDelayOffs;
  - the field-width constants PmuSettleWidth=8 and PmuTimeoutWidth=16.
- Sub-module chimera_pmu_seq: one cluster FSM with its counter. It takes target, settle, timeout and iso_ack, and outputs rst_n, clkgate_en, iso_en, on, busy and a timeout pulse.
- The top instantiates NumClusters of these plus the APB register file.

Test Plan:
- Reset: after reset, read 0x04 returns 0; outputs are rst_n=0x00, clkgate=0x1F, iso=0x1F; pslverr=0.
- Power-up timing (SETTLE=3):
  - Stimulus: write TARGET=0x01; iso_ack[0] falls 2 cycles after iso_en[0] falls.
  - Expect: clkgate_en[0] falls 1 cycle after the write, rst_n[0] rises 4 cycles later, then iso_en[0] falls 4 cycles after that.
  - Expect: STATUS=0x0000_0001 after the ack, and busy bit 16 is high during the sequence.
- Power-down ordering: from ON, write TARGET=0 with ack rising after 5 cycles. Expect the order iso_en=1, then rst_n=0 after the ack, then clkgate=1 after SETTLE+1 cycles, ending in OFF.
- Timeout:
  - Stimulus: TIMEOUT=8, iso_ack stuck at 1 during power-up.
  - Expect: ERR=0x01 and irq_o=1 after 8 DEISO cycles, and the cluster proceeds to ON.
  - Then W1C write 0x01 to 0x08: ERR=0 and irq_o=0.
- Mid-sequence retarget: write TARGET=1 then TARGET=0 two cycles later. Expect the cluster to complete the power-up to ON, then immediately run the power-down to OFF.
- APB error and concurrency:
  - Read 0x10: pslverr=1, prdata=0.
  - Write TARGET=0x1F: all 5 clusters sequence in lockstep with identical timing.
  - Assert rst_ni mid-sequence: all outputs return to reset values on the next edge.
